fp16_sub_seq: RTL

FP16_SUB_SEQ -- requirements
Module: fp16_sub_seq

---
 rtl/fp16_pkg.sv | 21 ++
 rtl/fp16_cla16.sv | 41 ++++
 rtl/fp16_unpack.sv | 21 ++
 rtl/fp16_sub_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - shared binary16 constants and FSM state type for fp16_sub_seq
package fp16_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS  = 15;

  localparam logic [15:0] QNAN = 16'h7E00;
  localparam logic [15:0] PINF = 16'h7C00;

  // ROUND is only reachable when FP16_SUB_ROUND_EN is defined
  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    SUB,
    NORM,
    ROUND,
    DONE
  } state_e;

endpackage

// File: rtl/fp16_cla16.sv
// rtl/fp16_cla16.sv - 16-bit adder built from 4-bit carry-lookahead groups
module fp16_cla16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o,
  output logic        cout_o
);

  logic [15:0] g;
  logic [15:0] p;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Each bit's carry comes from its group's prefix generate/propagate and the group carry-in
  always_comb begin
    logic cg;
    logic gg;
    logic pp;
    logic ci;
    sum_o = '0;
    cg    = cin_i;
    gg    = 1'b0;
    pp    = 1'b1;
    ci    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      gg = 1'b0;
      pp = 1'b1;
      for (int i = 0; i < 4; i++) begin
        ci               = gg | (pp & cg);
        sum_o[4*k+i]     = p[4*k+i] ^ ci;
        gg               = g[4*k+i] | (p[4*k+i] & gg);
        pp               = pp & p[4*k+i];
      end
      cg = gg | (pp & cg);
    end
    cout_o = cg;
  end

endmodule

// File: rtl/fp16_unpack.sv
// rtl/fp16_unpack.sv - combinational binary16 field split, hidden bit insertion, denormal flush
module fp16_unpack #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic [EXP_W+MAN_W:0] x_i,
  output logic                 sign_o,
  output logic [EXP_W-1:0]     exp_o,
  output logic [MAN_W:0]       sig_o,
  output logic                 is_zero_o,
  output logic                 is_special_o
);

  assign sign_o       = x_i[EXP_W+MAN_W];
  assign exp_o        = x_i[EXP_W+MAN_W-1:MAN_W];
  assign is_zero_o    = (exp_o == '0);
  assign is_special_o = (exp_o == '1);
  // Zero exponent flushes the whole operand (denormals included) to zero
  assign sig_o        = is_zero_o ? '0 : {1'b1, x_i[MAN_W-1:0]};

endmodule

// File: rtl/fp16_sub_seq.sv
// rtl/fp16_sub_seq.sv - multi-cycle binary16 subtractor y = a - b; FP16_SUB_ROUND_EN adds RNE rounding
module fp16_sub_seq #(
  parameter int EXP_W = fp16_pkg::EXP_W,
  parameter int MAN_W = fp16_pkg::MAN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] y,
  output logic                 overflow,
  output logic                 underflow
);
  import fp16_pkg::*;

  localparam int W       = EXP_W + MAN_W + 1;
  localparam int SIG_W   = MAN_W + 1;   // 1.M
  localparam int AL_W    = MAN_W + 4;   // 1.M plus guard, round, sticky
  localparam int MAG_W   = MAN_W + 5;   // aligned width plus carry-out
  localparam int EXP_MAX = 2 * BIAS + 1;

  state_e             state_q, state_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d, y_q, y_d;
  logic               sign_q, sign_d, eff_sub_q, eff_sub_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic [AL_W-1:0]    ml_q, ml_d, ms_q, ms_d;
  logic [MAG_W-1:0]   mag_q, mag_d;
  logic               ovf_q, ovf_d, unf_q, unf_d;

  logic               sa, sb, za, zb, xa, xb;
  logic [EXP_W-1:0]   ea, eb;
  logic [SIG_W-1:0]   siga, sigb;

  fp16_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
    .x_i(a_q), .sign_o(sa), .exp_o(ea), .sig_o(siga), .is_zero_o(za), .is_special_o(xa)
  );
  fp16_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
    .x_i(b_q), .sign_o(sb), .exp_o(eb), .sig_o(sigb), .is_zero_o(zb), .is_special_o(xb)
  );

  logic [EXP_W+SIG_W-1:0] key_a, key_b;
  logic                   a_big, sign_l;
  logic [EXP_W-1:0]       exp_l, exp_s, diff;
  logic [SIG_W-1:0]       sig_l, sig_s;
  logic [2*AL_W-1:0]      ext;
  logic [AL_W-1:0]        al_s;

  // Pick the larger magnitude and right-align the smaller one, folding lost bits into sticky
  always_comb begin
    key_a  = za ? '0 : {ea, siga};
    key_b  = zb ? '0 : {eb, sigb};
    a_big  = (key_a >= key_b);
    exp_l  = a_big ? ea : eb;
    exp_s  = a_big ? eb : ea;
    sig_l  = a_big ? siga : sigb;
    sig_s  = a_big ? sigb : siga;
    sign_l = a_big ? sa : sb;
    diff   = exp_l - exp_s;
    ext    = {sig_s, 3'b000, {AL_W{1'b0}}} >> diff;
    if (diff > EXP_W'(AL_W - 1)) begin
      al_s = {{(AL_W-1){1'b0}}, |sig_s};
    end else begin
      al_s = ext[2*AL_W-1:AL_W] | {{(AL_W-1){1'b0}}, |ext[AL_W-1:0]};
    end
  end

  logic [15:0] add_a, add_b, add_sum;
  logic        add_cout, unused_cla;

  assign add_a = {2'b00, ml_q};
  assign add_b = eff_sub_q ? ~{2'b00, ms_q} : {2'b00, ms_q};

  // Larger-first ordering guarantees the subtract never goes negative
  fp16_cla16 u_cla (
    .a_i(add_a), .b_i(add_b), .cin_i(eff_sub_q), .sum_o(add_sum), .cout_o(add_cout)
  );
  assign unused_cla = ^{add_sum[15], add_cout};

  logic [MAG_W-1:0] n_mag;
  logic [EXP_W:0]   n_exp;
  logic             n_exit, n_ovf, n_unf;

  // One normalization step: carry -> shift right once; else shift left until the hidden bit lands
  always_comb begin
    n_mag  = mag_q;
    n_exp  = {1'b0, exp_q};
    n_exit = 1'b0;
    n_ovf  = 1'b0;
    n_unf  = 1'b0;
    if (mag_q[MAG_W-1]) begin
      n_mag  = {1'b0, mag_q[MAG_W-1:2], mag_q[1] | mag_q[0]};
      n_exp  = {1'b0, exp_q} + 1'b1;
      n_exit = 1'b1;
      n_ovf  = (n_exp == (EXP_W+1)'(EXP_MAX));
    end else if (mag_q[MAG_W-2]) begin
      n_exit = 1'b1;
    end else if (exp_q == EXP_W'(1)) begin
      n_exit = 1'b1;
      n_unf  = 1'b1;
    end else begin
      n_mag  = {mag_q[MAG_W-2:0], 1'b0};
      n_exp  = {1'b0, exp_q} - 1'b1;
      n_exit = mag_q[MAG_W-3];
    end
  end

`ifdef FP16_SUB_ROUND_EN
  logic             r_up;
  logic [SIG_W:0]   r_sig;
  logic [EXP_W:0]   r_exp;
  logic [MAN_W-1:0] r_man;

  // Round to nearest even from guard/round/sticky; a significand carry bumps the exponent
  always_comb begin
    r_up  = mag_q[2] & (mag_q[1] | mag_q[0] | mag_q[3]);
    r_sig = {1'b0, mag_q[MAG_W-2:3]} + {{SIG_W{1'b0}}, r_up};
    r_exp = {1'b0, exp_q} + {{EXP_W{1'b0}}, r_sig[SIG_W]};
    r_man = r_sig[SIG_W] ? '0 : r_sig[MAN_W-1:0];
  end
`endif

  // Next-state and datapath register updates for each FSM state
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    y_d       = y_q;
    sign_d    = sign_q;
    eff_sub_d = eff_sub_q;
    exp_d     = exp_q;
    ml_d      = ml_q;
    ms_d      = ms_q;
    mag_d     = mag_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = {~b[W-1], b[W-2:0]};
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        if (xa || xb) begin
          y_d     = QNAN;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = DONE;
        end else begin
          sign_d    = sign_l;
          eff_sub_d = sa ^ sb;
          exp_d     = exp_l;
          ml_d      = {sig_l, 3'b000};
          ms_d      = al_s;
          state_d   = SUB;
        end
      end
      SUB: begin
        mag_d = add_sum[MAG_W-1:0];
        if (add_sum[MAG_W-1:0] == '0) begin
          y_d     = '0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = DONE;
        end else begin
          state_d = NORM;
        end
      end
      NORM: begin
        mag_d = n_mag;
        exp_d = n_exp[EXP_W-1:0];
        if (n_exit) begin
          if (n_ovf) begin
            y_d     = {sign_q, PINF[W-2:0]};
            ovf_d   = 1'b1;
            unf_d   = 1'b0;
            state_d = DONE;
          end else if (n_unf) begin
            y_d     = {sign_q, {(W-1){1'b0}}};
            ovf_d   = 1'b0;
            unf_d   = 1'b1;
            state_d = DONE;
          end else begin
`ifdef FP16_SUB_ROUND_EN
            state_d = ROUND;
`else
            y_d     = {sign_q, n_exp[EXP_W-1:0], n_mag[MAG_W-3:3]};
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
            state_d = DONE;
`endif
          end
        end
      end
`ifdef FP16_SUB_ROUND_EN
      ROUND: begin
        if (r_exp == (EXP_W+1)'(EXP_MAX)) begin
          y_d   = {sign_q, PINF[W-2:0]};
          ovf_d = 1'b1;
        end else begin
          y_d   = {sign_q, r_exp[EXP_W-1:0], r_man};
          ovf_d = 1'b0;
        end
        unf_d   = 1'b0;
        state_d = DONE;
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      y_q       <= '0;
      sign_q    <= 1'b0;
      eff_sub_q <= 1'b0;
      exp_q     <= '0;
      ml_q      <= '0;
      ms_q      <= '0;
      mag_q     <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      y_q       <= y_d;
      sign_q    <= sign_d;
      eff_sub_q <= eff_sub_d;
      exp_q     <= exp_d;
      ml_q      <= ml_d;
      ms_q      <= ms_d;
      mag_q     <= mag_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign y         = y_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule
